// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } muldiv_state_t;

  localparam int          MULDIV_ITER = 32;
  localparam logic [31:0] DIV0_QUOT   = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN     = 32'h8000_0000;

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, subtract if it fits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] divisor,
  input  logic             dividend_bit,
  output logic [WIDTH-1:0] rem_next,
  output logic             quot_bit
);

  logic [WIDTH:0] shifted;

  assign shifted  = {rem, dividend_bit};
  // The restored remainder is always below the divisor, so the low WIDTH bits of the difference suffice.
  assign quot_bit = shifted[WIDTH] || (shifted[WIDTH-1:0] >= divisor);
  assign rem_next = quot_bit ? (shifted[WIDTH-1:0] - divisor) : shifted[WIDTH-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: magnitude datapath, one bit per cycle, sign fixed at the end.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             resetn_i,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] s_o
);

  localparam int                CNT_W    = $clog2(MULDIV_ITER);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MULDIV_ITER - 1);

  muldiv_state_t      state;
  muldiv_op_t         op_q;
  logic               neg_q;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] prod;   // multiply: {accumulator, multiplier}; divide: low half is dividend/quotient
  logic [WIDTH-1:0]   opd;    // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   rem;

  // Request decode.
  muldiv_op_t       op_in;
  logic             a_signed, b_signed, a_sgn, b_sgn, res_neg;
  logic             is_div, is_quot, div_zero, div_ovf, fast;
  logic [WIDTH-1:0] a_mag, b_mag, fast_res;

  assign op_in = muldiv_op_t'(op_i);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (op_in)
      OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      OP_MULHSU: a_signed = 1'b1;
      default: ;
    endcase
  end

  assign a_sgn    = a_signed & a_i[WIDTH-1];
  assign b_sgn    = b_signed & b_i[WIDTH-1];
  assign a_mag    = a_sgn ? -a_i : a_i;
  assign b_mag    = b_sgn ? -b_i : b_i;
  assign res_neg  = (op_in == OP_REM) ? a_sgn : (a_sgn ^ b_sgn);

  assign is_div   = op_i[2];
  assign is_quot  = ~op_i[1];
  assign div_zero = is_div && (b_i == '0);
  assign div_ovf  = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                    (a_i == INT_MIN[WIDTH-1:0]) && (b_i == '1);
  assign fast     = div_zero || div_ovf;
  assign fast_res = div_zero ? (is_quot ? DIV0_QUOT[WIDTH-1:0] : a_i)
                             : (is_quot ? INT_MIN[WIDTH-1:0]   : '0);

  // Iteration datapath.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH-1:0]   rem_next, quot_next;
  logic               quot_bit;

  assign mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, (prod[0] ? opd : '0)};
  assign mul_next = {mul_sum, prod[WIDTH-1:1]};

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem          (rem),
    .divisor      (opd),
    .dividend_bit (prod[WIDTH-1]),
    .rem_next     (rem_next),
    .quot_bit     (quot_bit)
  );

  assign quot_next = {prod[WIDTH-2:0], quot_bit};

  // Final-iteration result with sign correction.
  logic [2*WIDTH-1:0] mul_fin;
  logic [WIDTH-1:0]   quot_fin, rem_fin, final_res;

  always_comb begin
    mul_fin  = neg_q ? -mul_next  : mul_next;
    quot_fin = neg_q ? -quot_next : quot_next;
    rem_fin  = neg_q ? -rem_next  : rem_next;
    case (op_q)
      OP_MUL:                       final_res = mul_fin[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_res = mul_fin[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:              final_res = quot_fin;
      default:                      final_res = rem_fin;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state <= ST_IDLE;
      op_q  <= OP_MUL;
      neg_q <= 1'b0;
      cnt   <= '0;
      prod  <= '0;
      opd   <= '0;
      rem   <= '0;
      s_o   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            op_q  <= op_in;
            neg_q <= res_neg;
            cnt   <= '0;
            rem   <= '0;
            if (fast) begin
              s_o   <= fast_res;
              state <= ST_DONE;
            end else begin
              prod  <= {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
              opd   <= is_div ? b_mag : a_mag;
              state <= ST_CALC;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_CALC: begin
          cnt <= cnt + CNT_W'(1);
          if (op_q[2]) begin
            prod[WIDTH-1:0] <= quot_next;
            rem             <= rem_next;
          end else begin
            prod <= mul_next;
          end
          if (cnt == CNT_LAST) begin
            s_o   <= final_res;
            state <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy_o = (state == ST_CALC);
  assign done_o = (state == ST_DONE);

endmodule
